// File: rtl/out_reg_write_ctrl_pkg.sv
// Shared types and default sizes for the output register write controller.
// op_t is sized by the package defaults, so instances keep DATA_W/ADDR_W at or below them.
package out_reg_ctrl_pkg;

  localparam int N_REGS = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(N_REGS);
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  typedef struct packed {
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

endpackage

// File: rtl/out_reg_write_ctrl_arbiter.sv
// Round-robin arbiter with a registered one-hot grant.
// The pointer advances only when the granted requester is accepted.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             arb_en,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] win;

  // Walk from farthest to nearest so the requester just after last_q wins.
  always_comb begin
    win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[IDX_W'((int'(last_q) + k) % N_REQ)]) begin
        win = N_REQ'(1) << IDX_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant  <= '0;
      last_q <= IDX_W'(N_REQ - 1);
    end else begin
      grant <= arb_en ? win : '0;
      if (accept) last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/out_reg_write_ctrl.sv
// Sequences arbitrated writes/clears into the strobe-clocked output register bank.
// Define OUT_REG_SHADOW_EN to add a shadow copy of the bank with a registered read port.
module out_reg_write_ctrl #(
  parameter int  N_REGS     = out_reg_ctrl_pkg::N_REGS,
  parameter int  DATA_W     = out_reg_ctrl_pkg::DATA_W,
  parameter int  N_REQ      = 2,
  parameter int  STROBE_CYC = 1,
  localparam int ADDR_W     = $clog2(N_REGS)
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_clr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [DATA_W-1:0]        bank_data,
  output logic [N_REGS-1:0]        bank_sel,
  output logic                     bank_clr,
  output logic                     busy,
  output logic                     wr_done,
  output logic                     addr_err
`ifdef OUT_REG_SHADOW_EN
  ,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
`endif
);

  import out_reg_ctrl_pkg::*;

  state_t            state_q, state_d;
  op_t               op_q, op_in;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, arb_en, addr_ok;
  logic [DATA_W-1:0] data_d;
  logic [N_REGS-1:0] sel_d;
  logic              clr_d, busy_d, done_d, err_d;

  assign accept  = |(req_valid & req_ready);
  assign arb_en  = (state_q == IDLE) && (req_ready == '0);
  assign addr_ok = int'(op_q.addr) < N_REGS;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk   (CLK),
    .rst   (CLR),
    .req   (req_valid),
    .arb_en(arb_en),
    .accept(accept),
    .grant (req_ready)
  );

  // The payload comes from whichever requester currently holds the grant.
  always_comb begin
    op_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        op_in.clr  = req_clr[i];
        op_in.addr = req_addr[i*ADDR_W +: ADDR_W];
        op_in.data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == STROBE) ? cnt_q + CNT_W'(1) : '0;
      if (accept) op_q <= op_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == CNT_W'(STROBE_CYC - 1)) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and then registered, so the bank sees no glitches.
  always_comb begin
    data_d = bank_data;
    sel_d  = '0;
    clr_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != IDLE) || (arb_en && (req_valid != '0));
    case (state_d)
      SETUP: if (!op_in.clr) data_d = op_in.data;
      STROBE: begin
        if (op_q.clr)    clr_d = 1'b1;
        else if (addr_ok) sel_d = N_REGS'(1) << op_q.addr;
        err_d = (state_q == SETUP) && !op_q.clr && !addr_ok;
      end
      HOLD:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bank_data <= '0;
      bank_sel  <= '0;
      bank_clr  <= 1'b0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      bank_data <= data_d;
      bank_sel  <= sel_d;
      bank_clr  <= clr_d;
      busy      <= busy_d;
      wr_done   <= done_d;
      addr_err  <= err_d;
    end
  end

`ifdef OUT_REG_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [N_REGS];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < N_REGS; i++) shadow_q[i] <= '0;
      rd_data <= '0;
    end else begin
      if (state_q == HOLD) begin
        if (op_q.clr) begin
          for (int i = 0; i < N_REGS; i++) shadow_q[i] <= '0;
        end else if (addr_ok) begin
          shadow_q[op_q.addr] <= op_q.data;
        end
      end
      rd_data <= (int'(rd_addr) < N_REGS) ? shadow_q[rd_addr] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_out_reg_write_ctrl.sv
// Self-checking bench for out_reg_write_ctrl: transaction-level reference model plus directed cases.
// Shadow read checks are built only when OUT_REG_SHADOW_EN is defined.
module tb_out_reg_write_ctrl;

  localparam int N_REGS     = 12;
  localparam int DATA_W     = 8;
  localparam int N_REQ      = 2;
  localparam int STROBE_CYC = 3;
  localparam int ADDR_W     = $clog2(N_REGS);

  logic                    CLK = 1'b0;
  logic                    CLR = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_clr = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       bank_data;
  logic [N_REGS-1:0]       bank_sel;
  logic                    bank_clr, busy, wr_done, addr_err;
`ifdef OUT_REG_SHADOW_EN
  logic [ADDR_W-1:0]       rd_addr = '0;
  logic [DATA_W-1:0]       rd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  out_reg_write_ctrl #(
    .N_REGS    (N_REGS),
    .DATA_W    (DATA_W),
    .N_REQ     (N_REQ),
    .STROBE_CYC(STROBE_CYC)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_clr  (req_clr),
    .req_addr (req_addr),
    .req_data (req_data),
    .bank_data(bank_data),
    .bank_sel (bank_sel),
    .bank_clr (bank_clr),
    .busy     (busy),
    .wr_done  (wr_done),
    .addr_err (addr_err)
`ifdef OUT_REG_SHADOW_EN
    ,
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: position within the current operation (-1 = none) plus arbitration state.
  int              m_pos = -1;
  int              m_last = N_REQ - 1;
  int              m_addr = 0;
  logic            m_clr = 1'b0;
  logic [7:0]      m_wdata = '0;
  logic [7:0]      m_data = '0;
  logic [N_REQ-1:0] m_ready = '0;

  task automatic model_step();
    bit found;
    if (CLR) begin
      m_pos = -1; m_last = N_REQ - 1; m_ready = '0; m_data = '0;
      m_clr = 1'b0; m_addr = 0; m_wdata = '0;
    end else if (m_pos >= 0) begin
      m_pos = (m_pos == STROBE_CYC + 1) ? -1 : m_pos + 1;
    end else if (m_ready != '0) begin
      for (int w = 0; w < N_REQ; w++) begin
        if (m_ready[w] && req_valid[w]) begin
          m_clr   = req_clr[w];
          m_addr  = int'(req_addr[w*ADDR_W +: ADDR_W]);
          m_wdata = req_data[w*DATA_W +: DATA_W];
          m_last  = w;
          m_pos   = 0;
        end
      end
      m_ready = '0;
    end else begin
      found = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        if (!found && req_valid[(m_last + k) % N_REQ]) begin
          m_ready = '0;
          m_ready[(m_last + k) % N_REQ] = 1'b1;
          found = 1;
        end
      end
    end
    if (m_pos == 0 && !m_clr) m_data = m_wdata;
  endtask

  initial begin
    bit strobe;
    forever begin
      @(posedge CLK);
      #1;
      model_step();
      strobe = (m_pos >= 1) && (m_pos <= STROBE_CYC);
      check_output("req_ready", 32'(req_ready), 32'(m_ready));
      check_output("bank_data", 32'(bank_data), 32'(m_data));
      check_output("bank_sel", 32'(bank_sel),
                   (strobe && !m_clr && m_addr < N_REGS) ? (32'd1 << m_addr) : 32'd0);
      check_output("bank_clr", 32'(bank_clr), 32'(strobe && m_clr));
      check_output("wr_done", 32'(wr_done), 32'(m_pos == STROBE_CYC + 1));
      check_output("addr_err", 32'(addr_err), 32'(m_pos == 1 && !m_clr && m_addr >= N_REGS));
      check_output("busy", 32'(busy), 32'((m_pos >= 0) || (m_ready != '0)));
    end
  end

  task automatic set_req(input int r, input logic clr, input int addr, input int data);
    req_clr[r] = clr;
    req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_data[r*DATA_W +: DATA_W] = DATA_W'(data);
    req_valid[r] = 1'b1;
  endtask

  // Issues one request and returns on the negedge of its SETUP cycle.
  task automatic apply_stimulus(input int r, input logic clr, input int addr, input int data);
    bit got;
    got = 0;
    @(negedge CLK);
    set_req(r, clr, addr, data);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK);
      if (req_ready[r]) got = 1;
    end
    @(negedge CLK);
    req_valid[r] = 1'b0;
    check_output("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int c = 0; c < 40 && !idle; c++) begin
      @(negedge CLK);
      if (!busy) idle = 1;
    end
    check_output("idle_timeout", 32'(idle), 32'd1);
  endtask

  task automatic observe(input int cycles, output int sel_cyc, output int clr_cyc,
                         output int done_cyc, output int err_cyc, output logic [N_REGS-1:0] sel_or);
    sel_cyc = 0; clr_cyc = 0; done_cyc = 0; err_cyc = 0; sel_or = '0;
    for (int c = 0; c < cycles; c++) begin
      if (c > 0) @(negedge CLK);
      if (bank_sel != '0) sel_cyc++;
      if (bank_clr) clr_cyc++;
      if (wr_done) done_cyc++;
      if (addr_err) err_cyc++;
      sel_or |= bank_sel;
    end
  endtask

  initial begin
    int sel_cyc, clr_cyc, done_cyc, err_cyc;
    logic [N_REGS-1:0] sel_or;
    int grants[$];
    int exp_grants[4] = '{1, 0, 1, 0};
    int exp_sel[6]  = '{'h000, 'h020, 'h020, 'h020, 'h000, 'h000};
    int exp_done[6] = '{0, 0, 0, 0, 1, 0};
    bit seen;

    repeat (3) @(negedge CLK);
    check_output("reset_sel", 32'(bank_sel), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    CLR = 1'b0;

    $display("[TB] single write addr 5 data 0xA5");
    apply_stimulus(0, 1'b0, 5, 'hA5);
    check_output("single_setup_data", 32'(bank_data), 32'hA5);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge CLK);
      check_output("single_sel", 32'(bank_sel), 32'(exp_sel[c]));
      check_output("single_done", 32'(wr_done), 32'(exp_done[c]));
    end
    check_output("single_busy_end", 32'(busy), 32'd0);

    $display("[TB] contention between requesters 0 and 1");
    @(negedge CLK);
    set_req(0, 1'b0, 1, 'h11);
    set_req(1, 1'b0, 2, 'h22);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      for (int r = 0; r < N_REQ; r++) begin
        if (req_ready[r] && req_valid[r]) grants.push_back(r);
      end
    end
    req_valid = '0;
    check_output("contention_grant_count", 32'(grants.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      check_output("contention_grant_order", 32'(grants[i]), 32'(exp_grants[i]));
    end
    wait_idle();

    $display("[TB] clear from requester 1");
    apply_stimulus(1, 1'b1, 0, 0);
    observe(6, sel_cyc, clr_cyc, done_cyc, err_cyc, sel_or);
    check_output("clear_clr_cycles", 32'(clr_cyc), 32'(STROBE_CYC));
    check_output("clear_sel_cycles", 32'(sel_cyc), 32'd0);
    check_output("clear_done_count", 32'(done_cyc), 32'd1);

    $display("[TB] highest in-range address 11");
    apply_stimulus(0, 1'b0, 11, 'h0B);
    observe(6, sel_cyc, clr_cyc, done_cyc, err_cyc, sel_or);
    check_output("top_addr_sel", 32'(sel_or), 32'h800);
    check_output("top_addr_err", 32'(err_cyc), 32'd0);

    $display("[TB] out-of-range address 13");
    apply_stimulus(0, 1'b0, 13, 'h77);
    check_output("bad_setup_data", 32'(bank_data), 32'h77);
    observe(6, sel_cyc, clr_cyc, done_cyc, err_cyc, sel_or);
    check_output("bad_err_count", 32'(err_cyc), 32'd1);
    check_output("bad_sel_cycles", 32'(sel_cyc), 32'd0);
    check_output("bad_done_count", 32'(done_cyc), 32'd1);

    $display("[TB] reset during strobe");
    apply_stimulus(0, 1'b0, 8, 'h5A);
    @(posedge CLK);
    #3;
    check_output("pre_reset_sel", 32'(bank_sel), 32'h100);
    CLR = 1'b1;
    #1;
    check_output("async_reset_sel", 32'(bank_sel), 32'd0);
    check_output("async_reset_data", 32'(bank_data), 32'd0);
    check_output("async_reset_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    observe(8, sel_cyc, clr_cyc, done_cyc, err_cyc, sel_or);
    check_output("post_reset_done", 32'(done_cyc), 32'd0);
    @(negedge CLK);
    set_req(0, 1'b0, 3, 'h33);
    set_req(1, 1'b0, 4, 'h44);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (req_ready != '0) seen = 1;
    end
    check_output("post_reset_first_grant", 32'(req_ready), 32'h1);
    @(negedge CLK);
    req_valid = '0;
    wait_idle();

`ifdef OUT_REG_SHADOW_EN
    $display("[TB] shadow read-back");
    rd_addr = ADDR_W'(7);
    apply_stimulus(0, 1'b0, 7, 'h3C);
    observe(5, sel_cyc, clr_cyc, done_cyc, err_cyc, sel_or);
    check_output("shadow_sel_cycles", 32'(sel_cyc), 32'(STROBE_CYC));
    @(negedge CLK);
    @(negedge CLK);
    check_output("shadow_rd_7", 32'(rd_data), 32'h3C);
    apply_stimulus(1, 1'b1, 0, 0);
    wait_idle();
    for (int a = 0; a < N_REGS + 2; a++) begin
      rd_addr = ADDR_W'(a);
      @(negedge CLK);
      check_output("shadow_rd_cleared", 32'(rd_data), 32'd0);
    end
`endif

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/out_reg_write_ctrl.md
Name: out_reg_write_ctrl

Overview:
- Sequences writes into the 16-entry output register bank, where each register is edge-clocked by its own select strobe and all share an 8-bit data bus and a clear line.
- Accepts write/clear requests from N_REQ requesters and arbitrates them round-robin.
- Drives data with setup and hold around a glitch-free, registered one-hot select pulse, so bank registers only ever see clean rising edges with stable data.
- Sits between control logic (host decoder, direction-update logic) and the output register bank.

Parameters:
- N_REGS, 16: number of bank registers; width of bank_sel.
- DATA_W, 8: data bus width.
- N_REQ, 2: number of requesters.
- STROBE_CYC, 1: cycles bank_sel/bank_clr stay high; legal range 1..4.
- Derived localparam ADDR_W = $clog2(N_REGS), which is 4 at default.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_ready  out  N_REQ  grant/accept; a transfer occurs when valid&&ready.
- req_clr  in  N_REQ  1 = clear-all request; addr/data ignored.
- req_addr  in  N_REQ*ADDR_W  target register index, packed per requester.
- req_data  in  N_REQ*DATA_W  write data, packed per requester.
- bank_data  out  DATA_W  shared bank data bus.
- bank_sel  out  N_REGS  one-hot register strobes; these are clocks in the bank.
- bank_clr  out  1  clear pulse to bank; top level ORs this with CLR.
- busy  out  1  high whenever the state is not IDLE.
- wr_done  out  1  one-cycle pulse on sequence completion.
- addr_err  out  1  one-cycle pulse for an accepted write with req_addr >= N_REGS.

Behaviour:
- Reset (CLR high, asynchronous):
  - State IDLE; all outputs 0: bank_data, bank_sel, bank_clr, req_ready, busy, wr_done, addr_err.
  - RR pointer set so requester 0 has highest priority.
  - CLR asserted mid-sequence drops bank_sel/bank_clr immediately and abandons the operation; no completion pulse.
- All outputs are driven directly from flops, with no combinational paths to bank_sel or bank_clr.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If any req_valid is high, req_ready is registered one-hot to the RR winner on the next cycle (GRANT sub-cycle in IDLE).
  - Acceptance happens at cycle T when valid&&ready; the operation is latched and the state moves to SETUP at T+1.
  - req_ready is high for exactly one cycle per grant.
  - Requesters hold valid and payload stable until accepted.
  - A requester that drops valid before ready is simply skipped.
- SETUP (1 cycle): bank_data = latched data (write) or unchanged (clear); bank_sel = 0.
- STROBE (STROBE_CYC cycles):
  - Write with in-range address: bank_sel = 1 << addr.
  - Out-of-range address: bank_sel stays 0 and addr_err pulses in the first STROBE cycle.
  - Clear: bank_clr = 1 and bank_sel = 0.
- HOLD (1 cycle): bank_sel = 0, bank_clr = 0, bank_data unchanged; wr_done pulses.
- Timing and throughput:
  - Sequence length from acceptance is 2+STROBE_CYC+1 cycles; with ready generation included, back-to-back operations complete every STROBE_CYC+4 cycles.
- bank_data retains the last written value until the next write's SETUP.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod N_REQ.
  - The pointer updates only on acceptance.
  - With all requesters continuously valid, grants alternate 0,1,0,1,... at N_REQ=2.
- busy = (state != IDLE) || (req_ready != 0).
- Simultaneous clear and write from different requesters are serialized by RR; there is no merging.

Optional Feature:
- Macro OUT_REG_SHADOW_EN.
- When defined:
  - Adds ports rd_addr (in, ADDR_W) and rd_data (out, DATA_W).
  - Keeps a shadow copy of every bank register, updated in the HOLD cycle of each in-range write.
  - Clear operations and CLR zero all shadow entries.
  - rd_data is a registered read with 1-cycle latency; out-of-range rd_addr returns 0.
- When undefined: no shadow storage and no rd_* ports.

Decomposition:
- Package out_reg_ctrl_pkg holds:
  - state_t enum {IDLE, SETUP, STROBE, HOLD};
  - default constants N_REGS, DATA_W, ADDR_W;
  - op_t struct {clr, addr, data}.
- Sub-module rr_arbiter (parameter N_REQ): takes req vector and an accept strobe, returns a one-hot grant; it owns the RR pointer.

Test Plan:
- Single write: req0 writes addr=5, data=0xA5.
  - bank_data=0xA5 in SETUP; bank_sel=0x0020 for STROBE_CYC cycles; wr_done one cycle after that; bank_sel=0 otherwise.
- Contention: req0 and req1 continuously valid with addr 1/2, data 0x11/0x22.
  - Grants alternate 0,1,0,1; bank_sel sequence 0x0002, 0x0004, ...
  - Data is stable one cycle before and one cycle after each strobe.
- Clear: req1 issues req_clr.
  - bank_clr high for STROBE_CYC cycles; bank_sel stays 0; wr_done pulses.
  - Shadow, if enabled, reads 0 at every address.
- Bad address: N_REGS=12, write addr=13 -> addr_err pulses once, bank_sel never asserts, wr_done still pulses.
- Reset mid-STROBE: assert CLR while bank_sel=0x0100.
  - bank_sel drops to 0 in the same cycle (async); outputs 0; no wr_done.
  - The next request is served by requester 0 first.
- STROBE_CYC=3, OUT_REG_SHADOW_EN defined: write addr=7, data=0x3C.
  - bank_sel high for exactly 3 cycles.
  - rd_addr=7 returns 0x3C one cycle after HOLD.
